fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction fetch stage for the LEGv8 pipeline. It sits upstream of the instruction ROM and downstream-feeds decode.
- Owns the PC register and drives the ROM address.
- Captures the returned 32-bit word into the IF/ID pipeline register.
- Resolves unconditional B instructions early, in fetch.
- Accepts stall and redirect/flush requests from later stages.

Parameters:
RESET_PC, 64'h0, PC value loaded on reset
ADDR_W, 64, PC/address width
INSTR_W, 32, instruction width

Ports:
CLK  input  1  clock, all state updates on rising edge
Reset  input  1  synchronous, active-high reset
imem_addr  output  64  address to instruction ROM; combinational copy of PC
imem_data  input  32  instruction word from ROM, valid in same cycle as imem_addr
stall  input  1  hold PC and IF/ID contents (decode hazard)
redirect_valid  input  1  taken branch/CBZ resolved downstream; flush and redirect
redirect_target  input  64  new PC when redirect_valid=1; bits [1:0] ignored
pc  output  64  current PC register
ifid_instr  output  32  registered instruction to decode
ifid_pc  output  64  registered PC of ifid_instr
ifid_valid  output  1  ifid_instr is a real instruction (0 = bubble)
ifid_btaken  output  1  ifid_instr was an unconditional B already taken in fetch
fetch_count  output  32  count of valid instructions delivered to IF/ID

Behaviour:
- Clock and reset: one clock, CLK; reset is synchronous and active-high, named Reset.
- Reset (sampled at CLK edge) overrides everything:
  - pc=RESET_PC, ifid_valid=0, ifid_instr=0, ifid_pc=0, ifid_btaken=0, fetch_count=0.
  - Reset asserted mid-stream discards any in-flight IF/ID contents on that edge.
- imem_addr = pc, combinational. ROM read is combinational. Latency: the word at PC appears on ifid_instr one edge after pc holds that address.
- B predecode, combinational on imem_data:
  - is_b = (imem_data[31:26]==6'b000101).
  - b_target = pc + (sign_extend(imem_data[25:0]) << 2), 64-bit, wrap modulo 2^64.
- Next-state priority per edge, highest first:
  1. Reset.
  2. redirect_valid: pc <= {redirect_target[63:2],2'b00}; ifid_valid <= 0; ifid_btaken <= 0; ifid_instr <= 0. Overrides stall.
  3. stall: pc, ifid_* and fetch_count all hold.
  4. is_b: pc <= b_target; IF/ID loads the B word with ifid_valid=1, ifid_btaken=1.
  5. Otherwise: pc <= pc+4; IF/ID loads imem_data, pc, valid=1, btaken=0.
- fetch_count increments by 1 on every edge where ifid_valid is written to 1. It wraps at 2^32-1 to 0.
- Unknown or X imem_data is passed through unchecked. is_b with X opcode must not be relied on; the bench keeps the ROM populated.
- pc[1:0] is always 00 after reset, provided RESET_PC is aligned.
- B targeting itself (imm26=0) is legal: pc stays constant and a valid B is delivered every cycle.
- No internal state machine beyond the PC and IF/ID registers. Bubble state is encoded by ifid_valid.

Decomposition:
- fetch_pkg holds:
  - B_OPCODE=6'b000101
  - INSTR_NOP=32'h0
  - localparams for ADDR_W/INSTR_W defaults
- One sub-module, b_predecode. It is combinational: imem_data and pc in, is_b and b_target out. It is reused later for decode-side checks.
- Top level holds the PC register, the priority mux, the IF/ID register and the counter.

Test Plan:
- Reset, then release with ROM 0x000=910003E1, 0x004=910007E2, 0x008=8B020021, 0x00C=8B020022, 0x010=17FFFFFC:
  - imem_addr steps 0,4,8,C,10 on consecutive cycles.
  - ifid_instr follows one cycle later with ifid_valid=1.
- Early B: when pc=0x10 and imem_data=17FFFFFC (imm26=-4):
  - next pc=0x00.
  - ifid_instr=17FFFFFC, ifid_pc=0x10, ifid_btaken=1.
  - Sequence loops 0→10→0 indefinitely.
  - fetch_count=5 after the first 5 delivered instructions.
- Stall 3 cycles at pc=0x08: pc, ifid_instr=910007E2 and fetch_count are held constant for 3 edges, then resume at 0x0C.
- Redirect during stall, with stall=1, redirect_valid=1, target=0x00C:
  - next pc=0x0C and ifid_valid=0.
  - the following cycle delivers 8B020022 with ifid_pc=0x0C.
- Redirect with misaligned target 0x013 → pc=0x010.
- Reset asserted at pc=0x0C with ifid_valid=1 → next edge: pc=RESET_PC, ifid_valid=0, fetch_count=0.
- Counter wrap: force fetch_count=FFFFFFFF via a directed reset-free run/backdoor; one delivered instruction → 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants for the LEGv8 instruction fetch stage and its predecoder.
package fetch_pkg;
  localparam int          DEF_ADDR_W   = 64;
  localparam int          DEF_INSTR_W  = 32;
  localparam logic [63:0] DEF_RESET_PC = 64'h0;
  localparam logic [5:0]  B_OPCODE     = 6'b000101;
  localparam logic [31:0] INSTR_NOP    = 32'h0;
endpackage

// File: rtl/b_predecode.sv
// Combinational predecode of an unconditional B: opcode match and PC-relative target.
module b_predecode
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int INSTR_W = DEF_INSTR_W
) (
  input  logic [INSTR_W-1:0] imem_data,
  input  logic [ADDR_W-1:0]  pc,
  output logic               is_b,
  output logic [ADDR_W-1:0]  b_target
);

  logic [25:0]       imm26;
  logic [ADDR_W-1:0] offset;

  assign imm26 = imem_data[25:0];
  assign is_b  = (imem_data[INSTR_W-1 -: 6] == B_OPCODE);

  // Word offset: sign-extend imm26 and scale by 4; the add wraps naturally.
  assign offset   = {{(ADDR_W-28){imm26[25]}}, imm26, 2'b00};
  assign b_target = pc + offset;

endmodule

// File: rtl/fetch_stage.sv
// LEGv8 fetch stage: PC register, redirect/stall/B priority mux, IF/ID register, delivery counter.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = DEF_RESET_PC,
  parameter int          ADDR_W   = DEF_ADDR_W,
  parameter int          INSTR_W  = DEF_INSTR_W
) (
  input  logic               CLK,
  input  logic               Reset,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic [ADDR_W-1:0]  pc,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0]  ifid_pc,
  output logic               ifid_valid,
  output logic               ifid_btaken,
  output logic [31:0]        fetch_count
);

  logic [ADDR_W-1:0]  pc_reg, pc_next;
  logic [INSTR_W-1:0] ifid_instr_reg, ifid_instr_next;
  logic [ADDR_W-1:0]  ifid_pc_reg, ifid_pc_next;
  logic               ifid_valid_reg, ifid_valid_next;
  logic               ifid_btaken_reg, ifid_btaken_next;
  logic [31:0]        count_reg, count_next;
  logic               is_b;
  logic [ADDR_W-1:0]  b_target;
  logic               unused_target_lsbs;

  assign unused_target_lsbs = ^redirect_target[1:0];

  b_predecode #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_b_predecode (
    .imem_data (imem_data),
    .pc        (pc_reg),
    .is_b      (is_b),
    .b_target  (b_target)
  );

  // Redirect beats stall; ifid_pc is left alone on a flush since the slot is a bubble.
  always_comb begin
    pc_next          = pc_reg;
    ifid_instr_next  = ifid_instr_reg;
    ifid_pc_next     = ifid_pc_reg;
    ifid_valid_next  = ifid_valid_reg;
    ifid_btaken_next = ifid_btaken_reg;
    count_next       = count_reg;
    if (redirect_valid) begin
      pc_next          = {redirect_target[ADDR_W-1:2], 2'b00};
      ifid_instr_next  = INSTR_W'(INSTR_NOP);
      ifid_valid_next  = 1'b0;
      ifid_btaken_next = 1'b0;
    end else if (!stall) begin
      pc_next          = is_b ? b_target : pc_reg + ADDR_W'(4);
      ifid_instr_next  = imem_data;
      ifid_pc_next     = pc_reg;
      ifid_valid_next  = 1'b1;
      ifid_btaken_next = is_b;
      count_next       = count_reg + 32'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      pc_reg          <= RESET_PC[ADDR_W-1:0];
      ifid_instr_reg  <= INSTR_W'(INSTR_NOP);
      ifid_pc_reg     <= '0;
      ifid_valid_reg  <= 1'b0;
      ifid_btaken_reg <= 1'b0;
      count_reg       <= '0;
    end else begin
      pc_reg          <= pc_next;
      ifid_instr_reg  <= ifid_instr_next;
      ifid_pc_reg     <= ifid_pc_next;
      ifid_valid_reg  <= ifid_valid_next;
      ifid_btaken_reg <= ifid_btaken_next;
      count_reg       <= count_next;
    end
  end

  assign imem_addr   = pc_reg;
  assign pc          = pc_reg;
  assign ifid_instr  = ifid_instr_reg;
  assign ifid_pc     = ifid_pc_reg;
  assign ifid_valid  = ifid_valid_reg;
  assign ifid_btaken = ifid_btaken_reg;
  assign fetch_count = count_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: driver queues hand-computed post-edge state, monitor compares.
module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [63:0] imem_addr;
  logic [31:0] imem_data;
  logic        stall;
  logic        redirect_valid;
  logic [63:0] redirect_target;
  logic [63:0] pc;
  logic [31:0] ifid_instr;
  logic [63:0] ifid_pc;
  logic        ifid_valid;
  logic        ifid_btaken;
  logic [31:0] fetch_count;

  fetch_stage #(
    .RESET_PC (64'h0),
    .ADDR_W   (64),
    .INSTR_W  (32)
  ) dut (
    .CLK             (CLK),
    .Reset           (Reset),
    .imem_addr       (imem_addr),
    .imem_data       (imem_data),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .pc              (pc),
    .ifid_instr      (ifid_instr),
    .ifid_pc         (ifid_pc),
    .ifid_valid      (ifid_valid),
    .ifid_btaken     (ifid_btaken),
    .fetch_count     (fetch_count)
  );

  always #5 CLK = ~CLK;

  logic [31:0] rom [0:31];
  assign imem_data = rom[imem_addr[6:2]];

  typedef struct {
    int          step;
    logic [63:0] pc;
    logic        valid;
    logic [31:0] instr;
    logic [63:0] ifpc;
    logic        chk_ifpc;
    logic        bt;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   step_no = 0;

  task automatic chk(input int s, input string name, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL step%0d %s: got %h want %h", s, name, act, want);
    end
  endtask

  // Monitor: one queued expectation is checked just after each rising edge.
  always @(posedge CLK) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      $display("step%0d pc=%h v=%0b instr=%h ifpc=%h bt=%0b cnt=%0d",
               e.step, pc, ifid_valid, ifid_instr, ifid_pc, ifid_btaken, fetch_count);
      chk(e.step, "pc", pc, e.pc);
      chk(e.step, "imem_addr", imem_addr, e.pc);
      chk(e.step, "ifid_valid", {63'd0, ifid_valid}, {63'd0, e.valid});
      chk(e.step, "ifid_instr", {32'd0, ifid_instr}, {32'd0, e.instr});
      if (e.chk_ifpc) chk(e.step, "ifid_pc", ifid_pc, e.ifpc);
      chk(e.step, "ifid_btaken", {63'd0, ifid_btaken}, {63'd0, e.bt});
      chk(e.step, "fetch_count", {32'd0, fetch_count}, {32'd0, e.cnt});
    end
  end

  // Called at a falling edge: drive inputs, queue the state expected after the next rising edge.
  task automatic step(input logic rst, input logic stl, input logic rdv, input logic [63:0] tgt,
                      input logic [63:0] e_pc, input logic e_v, input logic [31:0] e_instr,
                      input logic [63:0] e_ifpc, input logic e_chk_ifpc, input logic e_bt,
                      input logic [31:0] e_cnt);
    exp_t e;
    Reset = rst; stall = stl; redirect_valid = rdv; redirect_target = tgt;
    e.step = step_no; e.pc = e_pc; e.valid = e_v; e.instr = e_instr; e.ifpc = e_ifpc;
    e.chk_ifpc = e_chk_ifpc; e.bt = e_bt; e.cnt = e_cnt;
    exp_q.push_back(e);
    step_no++;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  localparam logic [31:0] I0 = 32'h910003E1;
  localparam logic [31:0] I1 = 32'h910007E2;
  localparam logic [31:0] I2 = 32'h8B020021;
  localparam logic [31:0] I3 = 32'h8B020022;
  localparam logic [31:0] IB = 32'h17FFFFFC;
  localparam logic [31:0] IS = 32'h14000000;

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 32'h0;
    rom[0] = I0; rom[1] = I1; rom[2] = I2; rom[3] = I3; rom[4] = IB;
    rom[8] = IS;
    Reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 64'h0;
    @(negedge CLK);

    //    rst   stl   rdv   tgt      pc      v     instr  ifpc    chk   bt    cnt
    step(1'b1, 1'b0, 1'b0, 64'h0,  64'h0,  1'b0, 32'h0, 64'h0,  1'b1, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b0, 64'h0,  64'h4,  1'b1, I0,    64'h0,  1'b1, 1'b0, 32'd1);
    step(1'b0, 1'b0, 1'b0, 64'h0,  64'h8,  1'b1, I1,    64'h4,  1'b1, 1'b0, 32'd2);
    step(1'b0, 1'b0, 1'b0, 64'h0,  64'hC,  1'b1, I2,    64'h8,  1'b1, 1'b0, 32'd3);
    step(1'b0, 1'b0, 1'b0, 64'h0,  64'h10, 1'b1, I3,    64'hC,  1'b1, 1'b0, 32'd4);
    // Early B back to 0
    step(1'b0, 1'b0, 1'b0, 64'h0,  64'h0,  1'b1, IB,    64'h10, 1'b1, 1'b1, 32'd5);
    step(1'b0, 1'b0, 1'b0, 64'h0,  64'h4,  1'b1, I0,    64'h0,  1'b1, 1'b0, 32'd6);
    step(1'b0, 1'b0, 1'b0, 64'h0,  64'h8,  1'b1, I1,    64'h4,  1'b1, 1'b0, 32'd7);
    // Three-cycle stall at pc=8
    for (int k = 0; k < 3; k++)
      step(1'b0, 1'b1, 1'b0, 64'h0, 64'h8, 1'b1, I1,    64'h4,  1'b1, 1'b0, 32'd7);
    step(1'b0, 1'b0, 1'b0, 64'h0,  64'hC,  1'b1, I2,    64'h8,  1'b1, 1'b0, 32'd8);
    step(1'b0, 1'b0, 1'b0, 64'h0,  64'h10, 1'b1, I3,    64'hC,  1'b1, 1'b0, 32'd9);
    step(1'b0, 1'b0, 1'b0, 64'h0,  64'h0,  1'b1, IB,    64'h10, 1'b1, 1'b1, 32'd10);
    step(1'b0, 1'b0, 1'b0, 64'h0,  64'h4,  1'b1, I0,    64'h0,  1'b1, 1'b0, 32'd11);
    // Redirect overrides stall
    step(1'b0, 1'b1, 1'b1, 64'hC,  64'hC,  1'b0, 32'h0, 64'h0,  1'b0, 1'b0, 32'd11);
    step(1'b0, 1'b0, 1'b0, 64'h0,  64'h10, 1'b1, I3,    64'hC,  1'b1, 1'b0, 32'd12);
    // Misaligned redirect target
    step(1'b0, 1'b0, 1'b1, 64'h13, 64'h10, 1'b0, 32'h0, 64'h0,  1'b0, 1'b0, 32'd12);
    step(1'b0, 1'b0, 1'b0, 64'h0,  64'h0,  1'b1, IB,    64'h10, 1'b1, 1'b1, 32'd13);
    step(1'b0, 1'b0, 1'b0, 64'h0,  64'h4,  1'b1, I0,    64'h0,  1'b1, 1'b0, 32'd14);
    step(1'b0, 1'b0, 1'b0, 64'h0,  64'h8,  1'b1, I1,    64'h4,  1'b1, 1'b0, 32'd15);
    step(1'b0, 1'b0, 1'b0, 64'h0,  64'hC,  1'b1, I2,    64'h8,  1'b1, 1'b0, 32'd16);
    // Mid-stream reset discards IF/ID
    step(1'b1, 1'b0, 1'b0, 64'h0,  64'h0,  1'b0, 32'h0, 64'h0,  1'b1, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b0, 64'h0,  64'h4,  1'b1, I0,    64'h0,  1'b1, 1'b0, 32'd1);
    // Counter wrap via backdoor preload
    force dut.count_reg = 32'hFFFF_FFFF;
    #1;
    release dut.count_reg;
    step(1'b0, 1'b0, 1'b0, 64'h0,  64'h8,  1'b1, I1,    64'h4,  1'b1, 1'b0, 32'd0);
    // B to itself: pc holds while valid Bs keep coming
    step(1'b0, 1'b0, 1'b1, 64'h20, 64'h20, 1'b0, 32'h0, 64'h0,  1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b0, 64'h0,  64'h20, 1'b1, IS,    64'h20, 1'b1, 1'b1, 32'd1);
    step(1'b0, 1'b0, 1'b0, 64'h0,  64'h20, 1'b1, IS,    64'h20, 1'b1, 1'b1, 32'd2);

    @(posedge CLK);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
